lcd_bus_arb: RTL and testbench

- Shares the single HD44780-style character LCD bus between two independent write clients, e.g. client 0 = playfield scroller, client 1 = score/status writer.
- Each client presents one byte-write request, either a command (rs=0) or data (rs=1). The block grants clients round-robin and drives the E-pulse and settle timing on the pins.
- Holds off all grants until the LCD power-up delay has elapsed.
- Sits between the display content logic and the top-level LCD pins. It replaces per-client LCD timing FSMs.

---
 rtl/lcd_bus_arb.sv | 130 +++++++++++++
 tb/tb_lcd_bus_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arb.sv
// rtl/lcd_bus_arb.sv - two-client round-robin arbiter and E/settle timing for an HD44780 character LCD bus
//
// Ports:
//   clk                  system clock
//   rst                  asynchronous reset, active low
//   i_req0/i_req1        client write request, held until the matching ack
//   i_rs0/i_rs1          client register select (0 = command, 1 = data)
//   i_data0/i_data1      client byte
//   o_ack0/o_ack1        one-cycle pulse once the client's transfer and settle time are done
//   o_busy               low only while idle and able to grant
//   o_grant              client currently or most recently served
//   o_lcd_rs, o_lcd_rw, o_lcd_e, o_lcd_data   LCD pins

module lcd_bus_arb #(
    parameter int unsigned PWRUP_CYC   = 1000000,
    parameter int unsigned E_PULSE_CYC = 50,
    parameter int unsigned DLY_CMD_CYC = 2500,
    parameter int unsigned DLY_CLR_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req0,
    input  logic       i_rs0,
    input  logic [7:0] i_data0,
    output logic       o_ack0,
    input  logic       i_req1,
    input  logic       i_rs1,
    input  logic [7:0] i_data1,
    output logic       o_ack1,
    output logic       o_busy,
    output logic       o_grant,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_e,
    output logic [7:0] o_lcd_data
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_HOLD,
        S_GAP
    } state_t;

    // Terminal counts: the counter restarts at 0 on every state entry, so a
    // state lasting N cycles leaves when the counter reads N-1.
    localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_CYC - 1);
    localparam logic [31:0] EHIGH_LAST = 32'(E_PULSE_CYC - 1);
    localparam logic [31:0] CMD_LAST   = 32'(DLY_CMD_CYC - 1);
    localparam logic [31:0] CLR_LAST   = 32'(DLY_CLR_CYC - 1);

    state_t      state;
    state_t      state_nx;
    logic [31:0] cnt;
    logic        ptr;        // client that wins when both request together
    logic        take;       // grant happens on this edge
    logic        grant_nx;
    logic        long_dly;
    logic [31:0] hold_last;

    // Clear and Return Home need the long settle; data writes never do,
    // whatever byte they carry.
    assign long_dly  = !o_lcd_rs && (o_lcd_data == 8'h01 || o_lcd_data == 8'h02 ||
                                     o_lcd_data == 8'h03);
    assign hold_last = long_dly ? CLR_LAST : CMD_LAST;

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        grant_nx = o_grant;
        case (state)
            S_PWRUP: begin
                if (cnt == PWRUP_LAST) state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (i_req0 || i_req1) begin
                    take     = 1'b1;
                    state_nx = S_SETUP;
                    grant_nx = (i_req0 && i_req1) ? ptr : i_req1;
                end
            end
            S_SETUP: begin
                state_nx = S_EHIGH;
            end
            S_EHIGH: begin
                if (cnt == EHIGH_LAST) state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (cnt == hold_last) state_nx = S_GAP;
            end
            S_GAP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_PWRUP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_PWRUP;
            cnt        <= 32'd0;
            ptr        <= 1'b0;
            o_grant    <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? 32'd0 : cnt + 32'd1;
            if (take) begin
                o_grant    <= grant_nx;
                ptr        <= ~grant_nx;
                o_lcd_rs   <= grant_nx ? i_rs1 : i_rs0;
                o_lcd_data <= grant_nx ? i_data1 : i_data0;
            end
        end
    end

    // Decoded straight from the state register so that an asynchronous reset
    // pulls E low immediately and drops any pending ack.
    assign o_lcd_e  = (state == S_EHIGH);
    assign o_busy   = (state != S_IDLE);
    assign o_ack0   = (state == S_GAP) && !o_grant;
    assign o_ack1   = (state == S_GAP) && o_grant;
    assign o_lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_bus_arb.sv
// tb/tb_lcd_bus_arb.sv - self-checking bench for lcd_bus_arb with directed and randomized transfers

module tb_lcd_bus_arb;

    localparam int PWRUP = 20;
    localparam int EP    = 4;
    localparam int DCMD  = 10;
    localparam int DCLR  = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, rs0, req1, rs1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, busy, grant, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic m_ptr;

    lcd_bus_arb #(
        .PWRUP_CYC  (PWRUP),
        .E_PULSE_CYC(EP),
        .DLY_CMD_CYC(DCMD),
        .DLY_CLR_CYC(DCLR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req0    (req0),
        .i_rs0     (rs0),
        .i_data0   (data0),
        .o_ack0    (ack0),
        .i_req1    (req1),
        .i_rs1     (rs1),
        .i_data1   (data1),
        .o_ack1    (ack1),
        .o_busy    (busy),
        .o_grant   (grant),
        .o_lcd_rs  (lcd_rs),
        .o_lcd_rw  (lcd_rw),
        .o_lcd_e   (lcd_e),
        .o_lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Settle time the LCD needs after a write, straight from the command set.
    function automatic int exp_delay(input logic rs, input logic [7:0] d);
        return (rs == 1'b0 && d >= 8'h01 && d <= 8'h03) ? DCLR : DCMD;
    endfunction

    // Round-robin reference: a lone requester wins; on a tie the pointer wins;
    // the pointer then favours the client that did not win.
    function automatic logic pick(input logic r0, input logic r1);
        logic w;
        w     = (r0 && r1) ? m_ptr : r1;
        m_ptr = ~w;
        return w;
    endfunction

    task automatic set_req(input int cl, input logic v);
        if (cl == 0) req0 = v;
        else         req1 = v;
    endtask

    task automatic set_byte(input int cl, input logic rs, input logic [7:0] d);
        if (cl == 0) begin rs0 = rs; data0 = d; end
        else         begin rs1 = rs; data1 = d; end
    endtask

    // Follows one transfer from its E rise to the ack and the return to idle.
    task automatic wait_xfer(input string tag, input int cl, input logic rs, input logic [7:0] d,
                             input bit corrupt, input bit drop_hold, input bit rel);
        int n, hi, lo;
        bit bad;
        n = 0;
        while (lcd_e !== 1'b1 && n < 200) begin tick(); n++; end
        check({tag, "_e_rise"}, 32'(n < 200), 32'd1);
        check({tag, "_grant"}, 32'(grant), 32'(cl));
        check({tag, "_rs"}, 32'(lcd_rs), 32'(rs));
        check({tag, "_data"}, 32'(lcd_data), 32'(d));
        if (corrupt) set_byte(cl, ~rs, 8'h55);
        bad = 1'b0;
        hi  = 0;
        while (lcd_e === 1'b1 && hi < 200) begin
            if (lcd_rs !== rs || lcd_data !== d || ack0 !== 1'b0 || ack1 !== 1'b0) bad = 1'b1;
            tick();
            hi++;
        end
        check({tag, "_e_high"}, 32'(hi), 32'(EP));
        if (drop_hold) set_req(cl, 1'b0);
        lo = 0;
        while (((cl == 0) ? ack0 : ack1) !== 1'b1 && lo < 500) begin
            if (lcd_e !== 1'b0 || lcd_rs !== rs || lcd_data !== d || ack0 !== 1'b0 || ack1 !== 1'b0)
                bad = 1'b1;
            tick();
            lo++;
        end
        check({tag, "_e_low"}, 32'(lo), 32'(exp_delay(rs, d)));
        if (((cl == 0) ? ack1 : ack0) !== 1'b0 || lcd_e !== 1'b0) bad = 1'b1;
        check({tag, "_pins_stable"}, 32'(bad), 32'd0);
        if (rel) set_req(cl, 1'b0);
        tick();
        check({tag, "_ack_single"}, 32'({ack0, ack1}), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Counts cycles from reset release to the first E high, optionally raising req0 on the way.
    task automatic measure_pwrup(input string tag, input int raise_at);
        int n;
        bit bad;
        n   = 0;
        bad = 1'b0;
        while (lcd_e !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (n == raise_at) req0 = 1'b1;
            if (ack0 !== 1'b0 || ack1 !== 1'b0) bad = 1'b1;
        end
        check({tag, "_no_ack"}, 32'(bad), 32'd0);
        // PWRUP cycles of wait, one idle cycle granting, one setup cycle.
        check({tag, "_first_e"}, 32'(n), 32'(PWRUP + 2));
    endtask

    logic       pend[2];
    logic       prs[2];
    logic [7:0] pd[2];

    task automatic new_req(input int cl);
        prs[cl] = 1'($urandom_range(0, 1));
        if (!prs[cl] && $urandom_range(0, 1) == 1) pd[cl] = 8'($urandom_range(0, 3));
        else                                         pd[cl] = 8'($urandom_range(0, 255));
        set_byte(cl, prs[cl], pd[cl]);
        set_req(cl, 1'b1);
        pend[cl] = 1'b1;
    endtask

    logic       tbl_rs[3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] tbl_d[3]  = '{8'h01, 8'h38, 8'h01};

    initial begin
        logic w;
        int   n;
        bit   bad;
        rst = 1'b0;
        req0 = 1'b0; rs0 = 1'b0; data0 = 8'h00;
        req1 = 1'b0; rs1 = 1'b0; data1 = 8'h00;
        m_ptr = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_e", 32'(lcd_e), 32'd0);
        check("rst_acks", 32'({ack0, ack1}), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_rs", 32'(lcd_rs), 32'd0);
        check("rst_rw", 32'(lcd_rw), 32'd0);
        check("rst_data", 32'(lcd_data), 32'd0);

        // Power-up hold with a request raised early
        set_byte(0, 1'b1, 8'h4F);
        rst = 1'b1;
        measure_pwrup("pwrup", 2);
        w = pick(1'b1, 1'b0);
        wait_xfer("pwrup", int'(w), 1'b1, 8'h4F, 1'b0, 1'b0, 1'b1);

        // Settle delay selection
        for (int i = 0; i < 3; i++) begin
            set_byte(0, tbl_rs[i], tbl_d[i]);
            req0 = 1'b1;
            w = pick(1'b1, 1'b0);
            wait_xfer($sformatf("dly%0d", i), int'(w), tbl_rs[i], tbl_d[i], 1'b0, 1'b0, 1'b1);
        end

        // Data captured at grant survives input changes
        set_byte(1, 1'b1, 8'hC0);
        req1 = 1'b1;
        w = pick(1'b0, 1'b1);
        wait_xfer("capture", int'(w), 1'b1, 8'hC0, 1'b1, 1'b0, 1'b1);

        // Fairness with both requesting continuously
        set_byte(0, 1'b1, 8'hA0);
        set_byte(1, 1'b1, 8'hB1);
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w = pick(1'b1, 1'b1);
            wait_xfer($sformatf("fair%0d", i), i % 2, 1'b1, (i % 2 == 1) ? 8'hB1 : 8'hA0,
                      1'b0, 1'b0, i == 5);
        end
        req0 = 1'b0;

        // Request dropped during the settle time still completes once
        set_byte(1, 1'b0, 8'h38);
        req1 = 1'b1;
        w = pick(1'b0, 1'b1);
        wait_xfer("abandon", int'(w), 1'b0, 8'h38, 1'b0, 1'b1, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (lcd_e !== 1'b0 || busy !== 1'b0 || ack1 !== 1'b0) bad = 1'b1;
            tick();
        end
        check("abandon_no_regrant", 32'(bad), 32'd0);

        // Reset during the E pulse
        set_byte(0, 1'b1, 8'h41);
        req0 = 1'b1;
        n = 0;
        while (lcd_e !== 1'b1 && n < 50) begin tick(); n++; end
        check("midrst_e_rise", 32'(n < 50), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_e", 32'(lcd_e), 32'd0);
        check("midrst_ack", 32'({ack0, ack1}), 32'd0);
        check("midrst_busy", 32'(busy), 32'd1);
        check("midrst_data", 32'(lcd_data), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        m_ptr = 1'b0;
        measure_pwrup("midrst", -1);
        w = pick(1'b1, 1'b0);
        wait_xfer("midrst", int'(w), 1'b1, 8'h41, 1'b0, 1'b0, 1'b1);

        // Randomized traffic against the round-robin model
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int it = 0; it < 16; it++) begin
            if (!pend[0] && $urandom_range(0, 1) == 1) new_req(0);
            if (!pend[1] && $urandom_range(0, 1) == 1) new_req(1);
            if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
            w = pick(pend[0], pend[1]);
            wait_xfer($sformatf("rnd%0d", it), int'(w), prs[w], pd[w], 1'b0, 1'b0, 1'b1);
            pend[w] = 1'b0;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
